// File: rtl/ads_frame_packer_pkg.sv
// Shared definitions for the ADS frame packer: lane indices, header layout, FSM states
// and small arithmetic helpers.
package ads_frame_packer_pkg;

    localparam int LANE0 = 0;
    localparam int LANE1 = 1;
    localparam int LANE2 = 2;
    localparam int LANE3 = 3;

    localparam logic [3:0] HDR_MASK = 4'hF;

    // Byte positions inside the 64-bit timestamp header word
    localparam int HDR_B_MSL   = 0;
    localparam int HDR_B_MSH   = 1;
    localparam int HDR_B_SEC   = 2;
    localparam int HDR_B_MIN   = 3;
    localparam int HDR_B_HOUR  = 4;
    localparam int HDR_B_DATE  = 5;
    localparam int HDR_B_MONTH = 6;
    localparam int HDR_B_YEAR  = 7;

    typedef enum logic {
        ST_IDLE,
        ST_COLLECT
    } pack_state_e;

    function automatic logic [63:0] rtc_header(
        input logic [7:0] yr, input logic [7:0] mo, input logic [7:0] dt, input logic [7:0] hr,
        input logic [7:0] mi, input logic [7:0] se, input logic [7:0] msh, input logic [7:0] msl);
        logic [63:0] h;
        h = '0;
        h[HDR_B_YEAR*8  +: 8] = yr;
        h[HDR_B_MONTH*8 +: 8] = mo;
        h[HDR_B_DATE*8  +: 8] = dt;
        h[HDR_B_HOUR*8  +: 8] = hr;
        h[HDR_B_MIN*8   +: 8] = mi;
        h[HDR_B_SEC*8   +: 8] = se;
        h[HDR_B_MSH*8   +: 8] = msh;
        h[HDR_B_MSL*8   +: 8] = msl;
        return h;
    endfunction

    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [1:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {7'b0, b};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

endpackage

// File: rtl/ads_pack_fifo.sv
// Synchronous show-ahead FIFO; head is valid whenever empty is low.
// A push while full is accepted only when a pop happens in the same cycle.
module ads_pack_fifo #(
    parameter int AW = 4,
    parameter int W  = 69
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  head,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    always_comb begin
        do_pop   = pop && (count_q != '0);
        do_push  = push && ((count_q != DEPTH_C) || do_pop);
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign full  = (count_q == DEPTH_C);
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/ads_frame_packer.sv
// Collects the four ADS lane samples into 64-bit set words, prefixes each frame with an
// RTC timestamp header and queues both into a show-ahead FIFO for the DDR3 stage.
module ads_frame_packer #(
    parameter int FRAME_SETS = 16,
    parameter int TIMEOUT    = 255,
    parameter int FIFO_AW    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] Ch0_Dataf_ads1,
    input  logic [15:0] Ch1_Dataf_ads1,
    input  logic [15:0] Ch0_Dataf_ads2,
    input  logic [15:0] Ch1_Dataf_ads2,
    input  logic        Ch0_Dataf_en_ads1,
    input  logic        Ch1_Dataf_en_ads1,
    input  logic        Ch0_Dataf_en_ads2,
    input  logic        Ch1_Dataf_en_ads2,
    input  logic [7:0]  ds_MsecondsL,
    input  logic [7:0]  ds_MsecondsH,
    input  logic [7:0]  ds_Seconds,
    input  logic [7:0]  ds_Minutes,
    input  logic [7:0]  ds_Hour,
    input  logic [7:0]  ds_Date,
    input  logic [7:0]  ds_Month,
    input  logic [7:0]  ds_Year,
    input  logic        out_ready,
    output logic [63:0] ads_dat,
    output logic [3:0]  ads_dat_en,
    output logic        ads_hdr,
    output logic        ovf,
    output logic [7:0]  ovf_cnt
);
    import ads_frame_packer_pkg::*;

    localparam int         SC_W      = (FRAME_SETS > 1) ? $clog2(FRAME_SETS) : 1;
    localparam logic [7:0] TIMEOUT_T = 8'(TIMEOUT);
    localparam int         FW        = 69;

    pack_state_e state_q, state_d;
    logic [63:0] lane_q, lane_d;
    logic [3:0]  mask_q, mask_d;
    logic [7:0]  timer_q, timer_d;
    logic [SC_W-1:0] set_cnt_q, set_cnt_d, next_set;
    logic        pend_vld_q, pend_vld_d;
    logic [63:0] pend_word_q, pend_word_d;
    logic [3:0]  pend_mask_q, pend_mask_d;
    logic        hdr_due_q, hdr_due_d;
    logic [63:0] hdr_word_q, hdr_word_d;
    logic        ovf_q, ovf_d;
    logic [7:0]  ovf_cnt_q, ovf_cnt_d;

    logic [3:0]  en, merged_mask, flush_mask;
    logic [63:0] din, en_bits, merged_word, flush_word, rtc;
    logic        flush, imm_hdr, collide_hdr, def_push, hdr_push, pend_wr;
    logic        drop_pend, drop_fifo;
    logic        fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [FW-1:0]    fifo_din, fifo_head;
    logic [FIFO_AW:0] fifo_count;

    assign en[LANE0] = Ch0_Dataf_en_ads1;
    assign en[LANE1] = Ch1_Dataf_en_ads1;
    assign en[LANE2] = Ch0_Dataf_en_ads2;
    assign en[LANE3] = Ch1_Dataf_en_ads2;
    assign din[LANE0*16 +: 16] = Ch0_Dataf_ads1;
    assign din[LANE1*16 +: 16] = Ch1_Dataf_ads1;
    assign din[LANE2*16 +: 16] = Ch0_Dataf_ads2;
    assign din[LANE3*16 +: 16] = Ch1_Dataf_ads2;
    assign en_bits = {{16{en[3]}}, {16{en[2]}}, {16{en[1]}}, {16{en[0]}}};
    assign rtc = rtc_header(ds_Year, ds_Month, ds_Date, ds_Hour,
                            ds_Minutes, ds_Seconds, ds_MsecondsH, ds_MsecondsL);

    always_comb begin
        state_d     = state_q;
        lane_d      = lane_q;
        mask_d      = mask_q;
        timer_d     = timer_q;
        set_cnt_d   = set_cnt_q;
        pend_vld_d  = pend_vld_q;
        pend_word_d = pend_word_q;
        pend_mask_d = pend_mask_q;
        ovf_d       = ovf_q;
        flush       = 1'b0;
        flush_word  = '0;
        flush_mask  = '0;
        imm_hdr     = 1'b0;
        collide_hdr = 1'b0;
        drop_pend   = 1'b0;
        merged_mask = mask_q | en;
        merged_word = (lane_q & ~en_bits) | (din & en_bits);
        next_set    = (set_cnt_q == SC_W'(FRAME_SETS - 1)) ? '0 : set_cnt_q + SC_W'(1);

        if (|(en & mask_q)) begin
            // Repeat strobe on a captured lane: close the old set, the new samples start the next one
            flush       = 1'b1;
            flush_word  = lane_q;
            flush_mask  = mask_q;
            lane_d      = din & en_bits;
            mask_d      = en;
            timer_d     = 8'd1;
            state_d     = ST_COLLECT;
            collide_hdr = (next_set == '0);
        end else if ((|en) || (state_q == ST_COLLECT)) begin
            if (state_q == ST_IDLE) begin
                imm_hdr = (set_cnt_q == '0) && !hdr_due_q;
            end
            if ((merged_mask == HDR_MASK) || ((state_q == ST_COLLECT) && (timer_q == TIMEOUT_T))) begin
                flush      = 1'b1;
                flush_word = merged_word;
                flush_mask = merged_mask;
                lane_d     = '0;
                mask_d     = '0;
                timer_d    = '0;
                state_d    = ST_IDLE;
            end else begin
                lane_d  = merged_word;
                mask_d  = merged_mask;
                timer_d = (state_q == ST_IDLE) ? 8'd1 : timer_q + 8'd1;
                state_d = ST_COLLECT;
            end
        end

        // A frame opened by a repeat strobe gets its header once the closed set has left pend
        def_push   = hdr_due_q && !pend_vld_q;
        hdr_due_d  = (hdr_due_q && !def_push) || collide_hdr;
        hdr_word_d = collide_hdr ? rtc : hdr_word_q;
        hdr_push   = imm_hdr || def_push;
        pend_wr    = pend_vld_q && !hdr_push;
        if (pend_wr) begin
            pend_vld_d = 1'b0;
        end
        if (flush) begin
            set_cnt_d = next_set;
            if (pend_vld_q && !pend_wr) begin
                drop_pend = 1'b1;
            end else begin
                pend_vld_d  = 1'b1;
                pend_word_d = flush_word;
                pend_mask_d = flush_mask;
            end
        end

        fifo_push = hdr_push || pend_wr;
        fifo_din  = hdr_push ? {1'b1, HDR_MASK, (imm_hdr ? rtc : hdr_word_q)}
                             : {1'b0, pend_mask_q, pend_word_q};
        fifo_pop  = out_ready && (fifo_count != '0);
        drop_fifo = fifo_push && fifo_full && !fifo_pop;
        if (drop_pend || drop_fifo) begin
            ovf_d = 1'b1;
        end
        ovf_cnt_d = sat_add8(ovf_cnt_q, {1'b0, drop_pend} + {1'b0, drop_fifo});
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            lane_q      <= '0;
            mask_q      <= '0;
            timer_q     <= '0;
            set_cnt_q   <= '0;
            pend_vld_q  <= 1'b0;
            pend_word_q <= '0;
            pend_mask_q <= '0;
            hdr_due_q   <= 1'b0;
            hdr_word_q  <= '0;
            ovf_q       <= 1'b0;
            ovf_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            lane_q      <= lane_d;
            mask_q      <= mask_d;
            timer_q     <= timer_d;
            set_cnt_q   <= set_cnt_d;
            pend_vld_q  <= pend_vld_d;
            pend_word_q <= pend_word_d;
            pend_mask_q <= pend_mask_d;
            hdr_due_q   <= hdr_due_d;
            hdr_word_q  <= hdr_word_d;
            ovf_q       <= ovf_d;
            ovf_cnt_q   <= ovf_cnt_d;
        end
    end

    ads_pack_fifo #(
        .AW (FIFO_AW),
        .W  (FW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (fifo_din),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign ads_dat    = fifo_empty ? 64'h0 : fifo_head[63:0];
    assign ads_dat_en = fifo_empty ? 4'h0  : fifo_head[67:64];
    assign ads_hdr    = fifo_empty ? 1'b0  : fifo_head[68];
    assign ovf        = ovf_q;
    assign ovf_cnt    = ovf_cnt_q;

endmodule
